// File: rtl/router_pkg.sv
// Shared types and header-field constants for the 1x3 router output buffers.
package router_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    typedef struct packed {
        logic       lfd;
        logic [7:0] data;
    } fifo_word_t;

    typedef logic [6:0] pkt_cnt_t;

    // Bytes still owed after a header: payload length plus the trailing parity byte.
    function automatic pkt_cnt_t hdr_pkt_cnt(input logic [HDR_LEN_MSB:0] hdr);
        return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: header-tagged byte FIFO
// that drives data_out back to zero once the current packet has drained.
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);
    import router_pkg::*;

    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    pkt_cnt_t          pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DEPTH-1:0]  lfd_q, lfd_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-2:0]  wr_idx_s, rd_idx_s;
    logic              wr_ok_s, rd_ok_s;
    logic              full_s, empty_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              rd_lfd_s;

    assign wr_idx_s  = wp_q[PTR_W-2:0];
    assign rd_idx_s  = rp_q[PTR_W-2:0];
    assign empty_s   = (wp_q == rp_q);
    assign full_s    = (wp_q[PTR_W-2:0] == rp_q[PTR_W-2:0]) && (wp_q[PTR_W-1] != rp_q[PTR_W-1]);
    assign wr_ok_s   = write_enb && !full_s;
    assign rd_ok_s   = read_enb && !empty_s;
    assign rd_data_s = mem_q[rd_idx_s];
    assign rd_lfd_s  = lfd_q[rd_idx_s];

    assign full     = full_s;
    assign empty    = empty_s;
    assign data_out = data_out_q;

    // Next-state for pointers, header tags, packet counter and read data.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        lfd_d      = lfd_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            wp_d       = {PTR_W{1'b0}};
            rp_d       = {PTR_W{1'b0}};
            lfd_d      = {DEPTH{1'b0}};
            pkt_cnt_d  = 7'd0;
            data_out_d = {DATA_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wp_d            = wp_q + PTR_W'(1);
                lfd_d[wr_idx_s] = lfd_state;
            end else begin
                wp_d = wp_q;
            end
            if (rd_ok_s) begin
                rp_d       = rp_q + PTR_W'(1);
                data_out_d = rd_data_s;
                if (rd_lfd_s) begin
                    // A new header always reloads, even if the previous packet was cut short.
                    pkt_cnt_d = hdr_pkt_cnt(rd_data_s[HDR_LEN_MSB:0]);
                end else if (pkt_cnt_q != 7'd0) begin
                    pkt_cnt_d = pkt_cnt_q - 7'd1;
                end else begin
                    pkt_cnt_d = pkt_cnt_q;
                end
            end else if (pkt_cnt_q == 7'd0) begin
                data_out_d = {DATA_W{1'b0}};
            end else begin
                data_out_d = data_out_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wp_q       <= {PTR_W{1'b0}};
            rp_q       <= {PTR_W{1'b0}};
            lfd_q      <= {DEPTH{1'b0}};
            pkt_cnt_q  <= 7'd0;
            data_out_q <= {DATA_W{1'b0}};
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            lfd_q      <= lfd_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (wr_ok_s && !soft_reset) begin
            mem_q[wr_idx_s] <= data_in;
        end
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
Per-destination output buffer of the 1x3 router.
- Stores bytes written by the router FSM/register stage, tagged with a header marker (lfd_state).
- Presents bytes on data_out to the destination side under read_enb.
- Tracks packet length from the header byte so data_out returns to 0 once the packet is fully drained.
- Three instances sit between the router core and the data_out_0..2 ports.

Parameters:
- DATA_W, 8, payload byte width
- DEPTH, 16, number of entries; power of two
- PTR_W, $clog2(DEPTH)+1, pointer width including wrap bit

Ports:
- clock  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- soft_reset  input  1  synchronous flush from synchronizer timeout, active-high
- write_enb  input  1  write request from router core
- read_enb  input  1  read request from destination side
- lfd_state  input  1  marks data_in as the header byte of a packet
- data_in  input  DATA_W  byte to store
- data_out  output  DATA_W  registered read data
- full  output  1  DEPTH entries stored
- empty  output  1  no entries stored

Behaviour:
- Storage: DEPTH words of DATA_W+1 bits, {lfd, data}. Write pointer wp and read pointer rp are PTR_W bits; the MSB is the wrap bit.
- empty = (wp == rp). full = (wp[PTR_W-2:0] == rp[PTR_W-2:0]) && (wp MSB != rp MSB). Both are combinational from registered pointers.
- resetn low (async):
  - wp, rp, pkt_cnt = 0
  - data_out = 0
  - all stored lfd bits cleared
  - empty = 1, full = 0
- soft_reset high at an edge:
  - Same effect as reset, taking effect on that edge.
  - Overrides any write_enb or read_enb in the same cycle.
- Write: write_enb && !full → mem[wp] <= {lfd_state, data_in}; wp <= wp+1.
- Write when full is dropped silently; no state changes.
- Read: read_enb && !empty → data_out <= mem[rp][DATA_W-1:0]; rp <= rp+1. Latency 1 clock from the read edge to valid data_out.
  - If the read word's lfd = 1: pkt_cnt <= data[7:2] + 1 (payload length plus parity byte).
  - Else if pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
- pkt_cnt width is 7 bits; maximum value 64.
- Cycles with no successful read:
  - pkt_cnt == 0 → data_out <= 0.
  - Otherwise data_out holds.
- A read_enb while empty is ignored; pkt_cnt and rp are unchanged.
- Simultaneous write and read:
  - Each side is qualified by full/empty as sampled at that edge. Occupancy is unchanged when both succeed.
  - When full: the read succeeds and the write is dropped.
  - When empty: the write succeeds and the read is ignored.
- Wrap-around: pointers increment modulo 2^PTR_W; indexing uses the low PTR_W-1 bits.
- Header with length field 0 → pkt_cnt = 1; only the parity byte follows.
- A header read while pkt_cnt != 0 (truncated previous packet) reloads pkt_cnt from the new header; no error flag.
- Reset mid-operation: all in-flight data is discarded. The next write after release lands at entry 0.

Decomposition:
- router_pkg:
  - DATA_W, FIFO_DEPTH localparams
  - HDR_LEN_MSB=7, HDR_LEN_LSB=2, HDR_ADDR_MSB=1, HDR_ADDR_LSB=0 constants
  - typedef struct packed {logic lfd; logic [7:0] data;} fifo_word_t
  - pkt_cnt_t (logic [6:0])
- No sub-module. Pointer, counter and storage logic stay inline; the block is small and single-clock.

Test Plan:
- Async reset: assert resetn low mid-cycle with the FIFO half full → immediately empty=1, full=0, data_out=0; after release, the first write lands at entry 0.
- Fill and overflow: write 0x01..0x10 (16 bytes) → full=1 after the 16th write edge. Then write 0x11 → dropped; reading 16 times returns 0x01..0x10, then empty=1.
- Packet drain: write header 0x0D with lfd=1 (len 3, addr 1), then 0xA1, 0xA2, 0xA3, parity 0x5B. Hold read_enb for 5 cycles → data_out = 0x0D, 0xA1, 0xA2, 0xA3, 0x5B; the next idle cycle gives data_out=0x00.
- Simultaneous read and write:
  - When full: read → 0x01 out, the write of 0x99 is dropped, full deasserts.
  - When empty: read and write of 0x42 together → empty deasserts, data_out unchanged; the next read returns 0x42.
- Soft reset mid-packet: after reading the header 0x11 plus 2 bytes, pulse soft_reset one cycle concurrent with write_enb → empty=1, pkt_cnt=0, data_out=0, and the concurrent write is discarded.
- Wrap-around: 40 interleaved write/read pairs of incrementing data, occupancy kept between 1 and 15 → read order matches write order across pointer wrap, with no false full/empty.
